// File: rtl/axi_master_wr_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the write engine and its slave.
interface axi_master_wr_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Write address channel
  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWLOCK;
  logic [3:0]            AWCACHE;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;

  // Write data channel
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  // Write response channel
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_master_wr_engine.sv
// AXI4 write-master engine: accepts burst commands and a beat stream from the
// decoder, issues AW ahead of W, generates WLAST from a queued burst length,
// and returns B responses with a sticky error flag.
module axi_master_wr_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    AClk,
  input  logic                    ARstn,

  axi_master_wr_engine_if.master  axi,

  input  logic                    cmd_valid_d,
  output logic                    cmd_ready_d,
  input  logic [ID_WIDTH-1:0]     cmd_id_d,
  input  logic [ADDR_WIDTH-1:0]   awaddr_d,
  input  logic [7:0]              awlen_d,
  input  logic [2:0]              awsize_d,
  input  logic [1:0]              awburst_d,
  input  logic                    awlock_d,
  input  logic [3:0]              awcache_d,
  input  logic [2:0]              awprot_d,

  input  logic [DATA_WIDTH-1:0]   wdata_d,
  input  logic [DATA_WIDTH/8-1:0] wstrb_d,
  input  logic                    wvalid_d,
  output logic                    wready_d,

  output logic [ID_WIDTH-1:0]     bid_d,
  output logic [1:0]              bresp_d,
  output logic                    wr_rsp_en_d,

  output logic [4:0]              outstanding_cnt,
  output logic                    err_flag,
  output logic                    busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = $clog2(MAX_OUTSTANDING);

  localparam logic [2:0]     SIZE_MAX   = 3'($clog2(STRB_WIDTH));
  localparam logic [4:0]     MAX_CNT    = 5'(MAX_OUTSTANDING);
  localparam logic [PTR_W:0] FIFO_DEPTH = (PTR_W+1)'(MAX_OUTSTANDING);

  typedef enum logic {
    W_IDLE,
    W_DATA
  } w_state_t;

  // ---------------------------------------------------------------------------
  // AW channel register
  // ---------------------------------------------------------------------------
  logic                  aw_valid_q;
  logic [ID_WIDTH-1:0]   awid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [2:0]            awsize_q;
  logic [1:0]            awburst_q;
  logic                  awlock_q;
  logic [3:0]            awcache_q;
  logic [2:0]            awprot_q;

  logic                  cmd_ready;
  logic                  cmd_hs;
  logic [2:0]            awsize_clamped;

  // ---------------------------------------------------------------------------
  // Burst-length FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]            fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        fifo_cnt_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [7:0]            fifo_head;

  // ---------------------------------------------------------------------------
  // W FSM
  // ---------------------------------------------------------------------------
  w_state_t              w_state_q, w_state_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  w_valid;
  logic                  w_ready;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  // ---------------------------------------------------------------------------
  // B channel / status
  // ---------------------------------------------------------------------------
  logic                  b_ready;
  logic                  b_hs;
  logic                  b_acc;
  logic [4:0]            cnt_q;
  logic                  err_q;
  logic                  rsp_en_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;

  // Command acceptance and size clamp
  always_comb begin
    cmd_ready      = ARstn & ~aw_valid_q & (cnt_q < MAX_CNT) & ~fifo_full;
    cmd_hs         = cmd_valid_d & cmd_ready;
    awsize_clamped = (awsize_d > SIZE_MAX) ? SIZE_MAX : awsize_d;
  end

  // AW register: load on command accept, hold until AWREADY
  always_ff @(posedge AClk) begin
    if (!ARstn) begin
      aw_valid_q <= 1'b0;
      awid_q     <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      awlock_q   <= 1'b0;
      awcache_q  <= '0;
      awprot_q   <= '0;
    end else if (cmd_hs) begin
      aw_valid_q <= 1'b1;
      awid_q     <= cmd_id_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awsize_q   <= awsize_clamped;
      awburst_q  <= awburst_d;
      awlock_q   <= awlock_d;
      awcache_q  <= awcache_d;
      awprot_q   <= awprot_d;
    end else if (aw_valid_q && axi.AWREADY) begin
      aw_valid_q <= 1'b0;
    end
  end

  // FIFO status decode
  always_comb begin
    fifo_full  = (fifo_cnt_q == FIFO_DEPTH);
    fifo_empty = (fifo_cnt_q == '0);
    fifo_head  = fifo_mem[rd_ptr_q];
  end

  // FIFO storage: payload only, no reset needed
  always_ff @(posedge AClk) begin
    if (cmd_hs) begin
      fifo_mem[wr_ptr_q] <= awlen_d;
    end
  end

  // FIFO pointers and occupancy; a push lands after the edge, so a same-cycle
  // pop only ever sees entries written earlier
  always_ff @(posedge AClk) begin
    if (!ARstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (cmd_hs) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({cmd_hs, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // W FSM state register
  always_ff @(posedge AClk) begin
    if (!ARstn) begin
      w_state_q  <= W_IDLE;
      beat_cnt_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // W FSM next state and data-path pass-through
  always_comb begin
    w_state_d  = w_state_q;
    beat_cnt_d = beat_cnt_q;
    fifo_pop   = 1'b0;
    w_valid    = 1'b0;
    w_ready    = 1'b0;
    w_last     = 1'b0;
    w_data     = '0;
    w_strb     = '0;
    unique case (w_state_q)
      W_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          beat_cnt_d = fifo_head;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        w_valid = wvalid_d;
        w_ready = axi.WREADY;
        w_last  = (beat_cnt_q == 8'd0);
        w_data  = wdata_d;
        w_strb  = wstrb_d;
        if (wvalid_d && axi.WREADY) begin
          if (w_last) begin
            // Chain straight into the next queued burst without an idle cycle
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              beat_cnt_d = fifo_head;
            end else begin
              w_state_d = W_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // B handshake qualification: responses with nothing outstanding are dropped
  always_comb begin
    b_ready = ARstn;
    b_hs    = axi.BVALID & b_ready;
    b_acc   = b_hs & (cnt_q != 5'd0);
  end

  // Outstanding counter, response capture and sticky error flag
  always_ff @(posedge AClk) begin
    if (!ARstn) begin
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rsp_en_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
    end else begin
      rsp_en_q <= b_acc;
      if (b_acc) begin
        bid_q   <= axi.BID;
        bresp_q <= axi.BRESP;
        if (axi.BRESP[1]) begin
          err_q <= 1'b1;
        end
      end
      unique case ({cmd_hs, b_acc})
        2'b10:   cnt_q <= cnt_q + 5'd1;
        2'b01:   cnt_q <= cnt_q - 5'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Output mapping
  assign axi.AWID    = awid_q;
  assign axi.AWADDR  = awaddr_q;
  assign axi.AWLEN   = awlen_q;
  assign axi.AWSIZE  = awsize_q;
  assign axi.AWBURST = awburst_q;
  assign axi.AWLOCK  = awlock_q;
  assign axi.AWCACHE = awcache_q;
  assign axi.AWPROT  = awprot_q;
  assign axi.AWVALID = aw_valid_q;

  assign axi.WDATA   = w_data;
  assign axi.WSTRB   = w_strb;
  assign axi.WLAST   = w_last;
  assign axi.WVALID  = w_valid;
  assign axi.BREADY  = b_ready;

  assign cmd_ready_d     = cmd_ready;
  assign wready_d        = w_ready;
  assign bid_d           = bid_q;
  assign bresp_d         = bresp_q;
  assign wr_rsp_en_d     = rsp_en_q;
  assign outstanding_cnt = cnt_q;
  assign err_flag        = err_q;
  assign busy            = (cnt_q != 5'd0) | aw_valid_q | (w_state_q == W_DATA);

endmodule

// File: doc/axi_master_wr_engine.md
Name: axi_master_wr_engine

Overview:
- Parametrised AXI4 write-master engine: the next-generation write path of the AXI master, generalised in data width, ID width and outstanding depth.
- Accepts burst commands and a write-data beat stream from the decoder, and drives AW/W/B.
- Supports up to MAX_OUTSTANDING in-flight bursts, with AW issued ahead of W data.
- Generates WLAST internally, returns B responses to the decoder and keeps error status.

Parameters:
ADDR_WIDTH, 32, AWADDR/awaddr_d width
DATA_WIDTH, 64, WDATA width; legal values 32/64/128/256; STRB_WIDTH = DATA_WIDTH/8
ID_WIDTH, 4, AWID/BID width
MAX_OUTSTANDING, 4, max accepted-but-unresponded bursts; power of two, 2..16; also the burst-length FIFO depth

Ports:
AClk  in  1  clock
ARstn  in  1  synchronous active-low reset
AWID  out  ID_WIDTH  write address ID
AWADDR  out  ADDR_WIDTH  burst start address
AWLEN  out  8  beats-1
AWSIZE  out  3  bytes per beat, log2
AWBURST  out  2  FIXED/INCR/WRAP
AWLOCK  out  1  lock type
AWCACHE  out  4  cache attributes
AWPROT  out  3  protection attributes
AWVALID  out  1  address valid
AWREADY  in  1  address ready
WDATA  out  DATA_WIDTH  write data
WSTRB  out  STRB_WIDTH  byte strobes
WLAST  out  1  last beat of burst
WVALID  out  1  data valid
WREADY  in  1  data ready
BID  in  ID_WIDTH  response ID
BRESP  in  2  response code
BVALID  in  1  response valid
BREADY  out  1  response ready
cmd_valid_d  in  1  decoder command valid
cmd_ready_d  out  1  command accepted when both high
cmd_id_d  in  ID_WIDTH  command ID
awaddr_d  in  ADDR_WIDTH  command address
awlen_d  in  8  command length
awsize_d  in  3  command size
awburst_d  in  2  command burst type
awlock_d  in  1  command lock
awcache_d  in  4  command cache
awprot_d  in  3  command prot
wdata_d  in  DATA_WIDTH  beat data
wstrb_d  in  STRB_WIDTH  beat strobes
wvalid_d  in  1  beat valid
wready_d  out  1  beat consumed when both high
bid_d  out  ID_WIDTH  returned ID
bresp_d  out  2  returned response
wr_rsp_en_d  out  1  one-cycle response strobe
outstanding_cnt  out  5  in-flight bursts
err_flag  out  1  sticky SLVERR/DECERR seen
busy  out  1  outstanding_cnt!=0 or AWVALID or W burst active

Behaviour:
- Reset (ARstn=0 at a rising AClk edge) clears all state. Outputs: AWVALID=0, WVALID=0, WLAST=0, BREADY=0, cmd_ready_d=0, wready_d=0, wr_rsp_en_d=0, outstanding_cnt=0, err_flag=0, busy=0; AW*/W*/bid_d/bresp_d payloads are 0.
- Reset mid-burst abandons all state immediately. No completion beats are sent.
- cmd_ready_d = ARstn & !AWVALID & (outstanding_cnt < MAX_OUTSTANDING) & !len_fifo_full (combinational).
- Command accept: the AW register loads cmd fields and AWVALID=1 on the next cycle. Latency from cmd handshake to AWVALID is 1 cycle.
- AWSIZE is clamped to log2(STRB_WIDTH) when awsize_d exceeds it.
- On accept, awlen_d is pushed to len_fifo and outstanding_cnt increments.
- AWVALID holds with stable payload until AWREADY; it clears on the handshake cycle.
- W FSM states:
  - IDLE: when len_fifo is non-empty, pop it, load beat_cnt = len, go to DATA.
  - DATA: WVALID = wvalid_d, wready_d = WREADY, WDATA/WSTRB pass through combinationally. WLAST = (beat_cnt==0).
  - Each W handshake decrements beat_cnt. A handshake with WLAST goes to IDLE, or pops the next length and stays in DATA when the FIFO is non-empty (zero-bubble back-to-back).
- W beats for burst N may precede or follow AWREADY for burst N; no ordering dependency is imposed.
- BREADY = 1 whenever out of reset.
- On a B handshake: bid_d/bresp_d are registered, wr_rsp_en_d=1 for exactly 1 cycle, outstanding_cnt decrements.
  - BRESP = 2'b10 or 2'b11 sets err_flag (sticky until reset).
  - A B handshake while outstanding_cnt==0 is a protocol error: ignored, counter unchanged, no wr_rsp_en_d.
- Command accept and B handshake in the same cycle: outstanding_cnt is unchanged.
- At outstanding_cnt == MAX_OUTSTANDING, cmd_ready_d=0 until a B handshake.
- awlen_d = 0 gives a single beat with WLAST=1.
- AWLEN=255 is supported (beat_cnt is 8 bits).

Test Plan:
- Single burst: cmd addr 0x1000, len 3, INCR, 64b; slave always ready -> AWVALID 1 cycle after accept; 4 W beats with WLAST on the 4th only; BRESP=00 -> wr_rsp_en_d pulse, bid_d echoes cmd_id_d, outstanding_cnt returns to 0.
- Outstanding limit: MAX_OUTSTANDING=4, BVALID withheld, issue 5 cmds -> 4 accepted, cmd_ready_d=0 with outstanding_cnt=4; one B -> 5th accepted next cycle.
- Backpressure: AWREADY low 10 cycles, WREADY toggling every cycle, len 7 -> AWADDR/AWID stable while pending; exactly 8 beats, no dropped or duplicated data (scoreboard), WLAST on beat 8.
- Back-to-back bursts len 0 then len 2 with data pre-queued -> beats 1 and 2 in consecutive cycles, WLAST on beats 1 and 4.
- Simultaneous command accept and B handshake at count 2 -> count stays 2. BRESP=2'b10 -> err_flag=1 and stays set after later OKAY responses.
- Reset mid-burst (beat 2 of 4) -> next cycle all valids are 0, outstanding_cnt=0; a new burst after reset completes normally. DATA_WIDTH=128 regression -> WSTRB 16 bits; awsize_d=5 is clamped to AWSIZE=4.
